// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: single-port memory handshake between the controller and memory.
// Latency: none; this interface is only a bundle of wires.
// Backpressure: MemReq is held until memory answers with MemReady.
interface multicycle_controller_if;
  logic MemReq;
  logic MemWrite;
  logic IorD;
  logic MemReady;

  // Controller side: issues requests and waits for completion.
  modport master (
    output MemReq,
    output MemWrite,
    output IorD,
    input  MemReady
  );

  // Memory side: observes requests and signals completion.
  modport slave (
    input  MemReq,
    input  MemWrite,
    input  IorD,
    output MemReady
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM that sequences a multicycle MIPS datapath (fetch/decode/exec/mem/wb).
// Latency: R-type/addi/sw take 4 cycles, lw 5 and beq/j 3 when MemReady answers the first request.
// Backpressure: the FSM stalls in FETCH/MEMRD/MEMWR until MemReady. After MEM_TIMEOUT wait cycles it pulses MemErr and refetches.
// Optional: define CONTROLLER_BNE_EN to add bne through the BRANCH_NE state (encoding 12).
module multicycle_controller #(
  parameter int ALUCTRL_W   = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  multicycle_controller_if.master mem,
  input  logic [5:0]           OP,
  input  logic [5:0]           Funct,
  input  logic                 Zero,
  output logic                 IRWrite,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           PCSrc,
  output logic                 PCEn,
  output logic                 Illegal,
  output logic                 MemErr,
  output logic [3:0]           State
);

  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
`ifdef CONTROLLER_BNE_EN
    , S_BNE   = 4'd12
`endif
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;

  logic       w_wait, w_tmo, w_funct_ok;
  logic       w_memreq, w_memwrite, w_iord, w_irwrite, w_regdst, w_memtoreg, w_regwrite;
  logic       w_alusrca, w_pcwrite, w_branch, w_branchne, w_illegal;
  logic [1:0] w_alusrcb, w_aluop, w_pcsrc;
  logic [2:0] w_alu3;

  // A memory state is waiting whenever memory has not answered yet this cycle.
  assign w_wait = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR)) && !mem.MemReady;
  assign w_tmo  = (MEM_TIMEOUT != 0) && w_wait && (r_cnt == CNT_W'(MEM_TIMEOUT));

  assign w_funct_ok = (Funct == 6'b100000) || (Funct == 6'b100010) || (Funct == 6'b100100) ||
                      (Funct == 6'b100101) || (Funct == 6'b101010);

  // State register; reset abandons any in-flight access and restarts at FETCH.
  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Wait counter: runs only while a memory state waits, cleared on completion, timeout or leaving the state.
  always_ff @(posedge CLK) begin
    if (!RST_N)                r_cnt <= '0;
    else if (!w_wait || w_tmo) r_cnt <= '0;
    else                       r_cnt <= r_cnt + 1'b1;
  end

  // Next-state and Moore control decode; every field defaults to 0.
  always_comb begin
    w_next     = r_state;
    w_memreq   = 1'b0;
    w_memwrite = 1'b0;
    w_iord     = 1'b0;
    w_irwrite  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_aluop    = 2'b00;
    w_pcsrc    = 2'b00;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_branchne = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_memreq  = 1'b1;
        w_alusrcb = 2'b01;
        if (mem.MemReady) begin
          w_irwrite = 1'b1;
          w_pcwrite = 1'b1;
          w_next    = S_DECODE;
        end else if (w_tmo) begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        w_alusrcb = 2'b11;
        case (OP)
          6'b100011, 6'b101011: w_next = S_MEMADR;
          6'b000000: begin
            if (w_funct_ok) begin
              w_next = S_EXECUTE;
            end else begin
              w_illegal = 1'b1;
              w_next    = S_FETCH;
            end
          end
          6'b000100: w_next = S_BRANCH;
          6'b001000: w_next = S_ADDIEX;
          6'b000010: w_next = S_JUMP;
`ifdef CONTROLLER_BNE_EN
          6'b000101: w_next = S_BNE;
`endif
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = (OP == 6'b101011) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_memreq = 1'b1;
        w_iord   = 1'b1;
        if (mem.MemReady) w_next = S_MEMWB;
        else if (w_tmo)   w_next = S_FETCH;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        w_memreq   = 1'b1;
        w_memwrite = 1'b1;
        w_iord     = 1'b1;
        if (mem.MemReady || w_tmo) w_next = S_FETCH;
      end
      S_EXECUTE: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b01;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
        w_next    = S_FETCH;
      end
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_FETCH;
      end
`ifdef CONTROLLER_BNE_EN
      S_BNE: begin
        w_alusrca  = 1'b1;
        w_aluop    = 2'b01;
        w_pcsrc    = 2'b01;
        w_branchne = 1'b1;
        w_next     = S_FETCH;
      end
`endif
      default: w_next = S_FETCH;
    endcase
  end

  // ALU decoder: the operation comes from ALUOp, or from Funct for R-type.
  always_comb begin
    w_alu3 = 3'b010;
    case (w_aluop)
      2'b01: w_alu3 = 3'b110;
      2'b10: begin
        case (Funct)
          6'b100010: w_alu3 = 3'b110;
          6'b100100: w_alu3 = 3'b000;
          6'b100101: w_alu3 = 3'b001;
          6'b101010: w_alu3 = 3'b111;
          default:   w_alu3 = 3'b010;
        endcase
      end
      default: w_alu3 = 3'b010;
    endcase
  end

  // Write strobes and pulses are masked while reset is asserted, so nothing commits during reset.
  assign mem.MemReq   = w_memreq & RST_N;
  assign mem.MemWrite = w_memwrite & RST_N;
  assign mem.IorD     = w_iord;
  assign IRWrite      = w_irwrite & RST_N;
  assign RegDst       = w_regdst;
  assign MemtoReg     = w_memtoreg;
  assign RegWrite     = w_regwrite & RST_N;
  assign ALUSrcA      = w_alusrca;
  assign ALUSrcB      = w_alusrcb;
  assign ALUControl   = ALUCTRL_W'(w_alu3);
  assign PCSrc        = w_pcsrc;
  assign PCEn         = (w_pcwrite | (w_branch & Zero) | (w_branchne & ~Zero)) & RST_N;
  assign Illegal      = w_illegal & RST_N;
  assign MemErr       = w_tmo & RST_N;
  assign State        = r_state;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle MIPS control unit; successor to the single-cycle combinational decoder.
- Moore FSM sequences fetch/decode/execute/memory/writeback over several cycles, sharing one ALU and one memory port.
- Adds a memory request/ready handshake with a timeout, illegal-instruction detection and PC-enable generation.
- Sits between the instruction register and the multicycle datapath.

Parameters:
- ALUCTRL_W, 3: ALUControl width; the 3-bit codes below are zero-extended when wider; must be >= 3.
- MEM_TIMEOUT, 15: cycles to wait for MemReady before flagging MemErr and retrying; 0 disables the timeout.

Ports:
- CLK  input  1  clock, rising edge
- RST_N  input  1  reset, synchronous, active-low
- OP  input  6  opcode from IR
- Funct  input  6  funct field from IR
- Zero  input  1  ALU zero flag
- MemReady  input  1  memory completes the current access this cycle
- MemReq  output  1  memory access request
- MemWrite  output  1  store strobe (valid with MemReq)
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- IRWrite  output  1  instruction register load
- RegDst  output  1  0 = rt, 1 = rd
- MemtoReg  output  1  writeback source: 0 = ALUOut, 1 = data
- RegWrite  output  1  register file write
- ALUSrcA  output  1  0 = PC, 1 = A
- ALUSrcB  output  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- ALUControl  output  ALUCTRL_W  ALU operation
- PCSrc  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- PCEn  output  1  PC load
- Illegal  output  1  one-cycle pulse on undecodable instruction
- MemErr  output  1  one-cycle pulse on memory timeout
- State  output  4  current state encoding, for debug

Behaviour:
- All outputs are Moore-decoded from the state; any field not listed for a state is 0.
- PCEn = PCWrite | (Branch & Zero), where PCWrite and Branch are internal.
- RST_N low at a clock edge: state <= FETCH, wait counter <= 0. This applies mid-instruction too; any in-flight access is abandoned.
- Next-state decode uses OP/Funct as sampled in DECODE and MEMADR.
- ALU decoder, by ALUOp:
  - 00 -> 010 (add)
  - 01 -> 110 (sub)
  - 10 -> by Funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111
- States (encoding 0 to 11):
  - FETCH(0): MemReq=1, IorD=0, ALUSrcB=01, ALUOp=00. While MemReady=0, stay. When MemReady=1, IRWrite=1 and PCWrite=1 that cycle, then -> DECODE.
  - DECODE(1): ALUSrcB=11, ALUOp=00. Transitions by OP:
    - 100011/101011 -> MEMADR
    - 000000 with a legal Funct -> EXECUTE
    - 000100 -> BRANCH
    - 001000 -> ADDIEX
    - 000010 -> JUMP
    - anything else -> Illegal=1 this cycle, -> FETCH (no write)
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD; sw -> MEMWR.
  - MEMRD(3): MemReq=1, IorD=1. Wait for MemReady, then -> MEMWB.
  - MEMWB(4): MemtoReg=1, RegWrite=1 -> FETCH.
  - MEMWR(5): MemReq=1, MemWrite=1, IorD=1. Wait for MemReady, then -> FETCH.
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - ALUWB(7): RegDst=1, RegWrite=1 -> FETCH.
  - BRANCH(8): ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1 -> FETCH.
  - ADDIEX(9): ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
  - ADDIWB(10): RegWrite=1 -> FETCH.
  - JUMP(11): PCSrc=10, PCWrite=1 -> FETCH.
- Wait counter:
  - Clears on entering FETCH, MEMRD or MEMWR, and whenever MemReady=1.
  - Increments each cycle the state waits.
  - If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT with MemReady=0: MemErr=1 that cycle, state -> FETCH (retry fetch), no IRWrite, RegWrite or PCWrite.
- MemReady outside FETCH/MEMRD/MEMWR is ignored.
- Latency with MemReady=1 on first request:
  - R-type and addi: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq and j: 3 cycles

Optional Feature:
- Macro CONTROLLER_BNE_EN.
- When defined: OP 000101 in DECODE -> BRANCH_NE (encoding 12). BRANCH_NE drives the same outputs as BRANCH, but PCEn = BranchNe & ~Zero; then -> FETCH.
- When undefined: 000101 is illegal (Illegal pulse, -> FETCH) and encoding 12 is unused.

Test Plan:
- Reset held low 2 cycles mid-MEMRD, then released with MemReady=1 -> State=0, all writes 0 during reset; the first post-reset cycle shows MemReq=1, IRWrite=1, PCEn=1.
- add (OP=0, Funct=100000), MemReady=1 -> states 0,1,6,7; ALUControl=010 in EXECUTE; RegWrite=1, RegDst=1 in ALUWB only.
- lw with MemReady low for 3 cycles in MEMRD -> MemReq held 4 cycles, then MEMWB with MemtoReg=1, RegWrite=1; total 8 cycles.
- beq with Zero=1 -> PCEn=1, PCSrc=01 in BRANCH. With Zero=0 -> PCEn=0. With CONTROLLER_BNE_EN, OP=000101 and Zero=0 -> PCEn=1.
- OP=111111, and separately OP=0 with Funct=000111 -> Illegal pulses exactly 1 cycle in DECODE, next state FETCH, no RegWrite.
- MEM_TIMEOUT=4, MemReady held 0 in FETCH -> MemErr pulses on the 5th cycle, state stays FETCH, the pulse repeats every 5 cycles, and IRWrite stays 0.
